// File: rtl/ex_operand_stage_pkg.sv
// Shared types and ALU operation encodings for the ID/EX operand stage.
// Forward-source selection is an enum so the operand mux decodes by name.
package ex_operand_stage_pkg;

    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;
    localparam logic [3:0] ALU_XXX  = 4'd15;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Combinational 3-way operand select: MEM result, WB result or latched
// register-file value. Register 0 is hardwired and never forwarded.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_val,
    input  logic          mem_en,
    input  logic [RW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd_val
);

    fwd_sel_e sel_s;

    // Source priority: the younger MEM result shadows the older WB result.
    always_comb begin
        sel_s = FWD_REG;
        if (src == {RW{1'b0}}) begin
            sel_s = FWD_REG;
        end else if (mem_en && (mem_addr == src)) begin
            sel_s = FWD_MEM;
        end else if (wb_en && (wb_addr == src)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_REG;
        end
    end

    // Operand data select.
    always_comb begin
        fwd_val = reg_val;
        case (sel_s)
            FWD_MEM: fwd_val = mem_data;
            FWD_WB:  fwd_val = wb_data;
            FWD_REG: fwd_val = reg_val;
            default: fwd_val = reg_val;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, shamt/immediate
// substitution and load-use hazard detection feeding the ALU.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_dest,
    input  logic [15:0]   id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_aluop,
    input  logic          id_a_shamt,
    input  logic          id_b_imm,
    input  logic          id_imm_sext,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          ext_stall,
    input  logic          mem_fwd_en,
    input  logic [RW-1:0] mem_fwd_addr,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          wb_fwd_en,
    input  logic [RW-1:0] wb_fwd_addr,
    input  logic [DW-1:0] wb_fwd_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_valid,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          hazard_stall
);

    logic [RW-1:0] rs_r, rt_r, dest_r;
    logic [DW-1:0] rs_val_r, rt_val_r, imm_r;
    logic [4:0]    shamt_r;
    logic [3:0]    aluop_r;
    logic          a_shamt_r, b_imm_r;
    logic          valid_r, reg_write_r, mem_read_r, mem_write_r;
    logic          hazard_s;
    logic [DW-1:0] imm_ext_s, rs_fwd_s, rt_fwd_s;

    assign imm_ext_s = {{(DW-16){id_imm_sext & id_imm[15]}}, id_imm};

    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        hazard_s = 1'b0;
        if (valid_r && mem_read_r && id_valid && (dest_r != {RW{1'b0}})) begin
            hazard_s = (dest_r == id_rs) || (id_uses_rt && (dest_r == id_rt));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // EX register: flush beats ext_stall, which beats the load-use bubble;
    // a bubble only clears control so a held operand field does no harm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_r        <= {RW{1'b0}};
            rt_r        <= {RW{1'b0}};
            dest_r      <= {RW{1'b0}};
            rs_val_r    <= {DW{1'b0}};
            rt_val_r    <= {DW{1'b0}};
            imm_r       <= {DW{1'b0}};
            shamt_r     <= 5'd0;
            aluop_r     <= ALU_XXX;
            a_shamt_r   <= 1'b0;
            b_imm_r     <= 1'b0;
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (flush || (!ext_stall && hazard_s)) begin
            dest_r      <= {RW{1'b0}};
            aluop_r     <= ALU_XXX;
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (!ext_stall) begin
            rs_r        <= id_rs;
            rt_r        <= id_rt;
            dest_r      <= id_dest;
            rs_val_r    <= id_rs_val;
            rt_val_r    <= id_rt_val;
            imm_r       <= imm_ext_s;
            shamt_r     <= id_shamt;
            aluop_r     <= id_aluop;
            a_shamt_r   <= id_a_shamt;
            b_imm_r     <= id_b_imm;
            valid_r     <= id_valid;
            reg_write_r <= id_reg_write;
            mem_read_r  <= id_mem_read;
            mem_write_r <= id_mem_write;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src      (rs_r),
        .reg_val  (rs_val_r),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_addr  (wb_fwd_addr),
        .wb_data  (wb_fwd_data),
        .fwd_val  (rs_fwd_s)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src      (rt_r),
        .reg_val  (rt_val_r),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_addr  (wb_fwd_addr),
        .wb_data  (wb_fwd_data),
        .fwd_val  (rt_fwd_s)
    );

    assign alu_a         = a_shamt_r ? {{(DW-5){1'b0}}, shamt_r} : rs_fwd_s;
    assign alu_b         = b_imm_r ? imm_r : rt_fwd_s;
    assign ex_store_data = rt_fwd_s;
    assign alu_op        = aluop_r;
    assign ex_valid      = valid_r;
    assign ex_dest       = dest_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_mem_write  = mem_write_r;
    assign hazard_stall  = hazard_s;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected EX outputs are queued when
// an instruction is driven and popped for comparison after the capture edge.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rt, id_a_shamt, id_b_imm, id_imm_sext;
    logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
    logic [31:0] id_rs_val, id_rt_val;
    logic [15:0] id_imm;
    logic [3:0]  id_aluop;
    logic        id_reg_write, id_mem_read, id_mem_write, flush, ext_stall;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_addr, wb_fwd_addr;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  op;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
        .id_a_shamt(id_a_shamt), .id_b_imm(id_b_imm), .id_imm_sext(id_imm_sext),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ext_stall(ext_stall),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [3:0] op, input logic v);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.sd = sd; e.op = op; e.v = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".a"},  alu_a, e.a);
            check({e.tag, ".b"},  alu_b, e.b);
            check({e.tag, ".sd"}, ex_store_data, e.sd);
            check({e.tag, ".op"}, {28'd0, alu_op}, {28'd0, e.op});
            check({e.tag, ".v"},  {31'd0, ex_valid}, {31'd0, e.v});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [31:0] rsv, input logic [4:0] rt,
                          input logic [31:0] rtv, input logic [4:0] dest, input logic [3:0] op);
        id_valid = 1'b1; id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv;
        id_dest = dest; id_aluop = op; id_uses_rt = 1'b1; id_imm = 16'd0; id_shamt = 5'd0;
        id_a_shamt = 1'b0; id_b_imm = 1'b0; id_imm_sext = 1'b0; id_reg_write = 1'b1;
        id_mem_read = 1'b0; id_mem_write = 1'b0;
    endtask

    task automatic set_lw_r5();
        set_id(5'd1, 32'h100, 5'd0, 32'd0, 5'd5, ALU_ADDU);
        id_uses_rt = 1'b0; id_b_imm = 1'b1; id_imm = 16'd4; id_imm_sext = 1'b1;
        id_mem_read = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        mem_fwd_en = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = 32'd0;
        wb_fwd_en = 1'b0; wb_fwd_addr = 5'd0; wb_fwd_data = 32'd0;
        set_id(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, ALU_ADDU);
        id_valid = 1'b0;
        step();
        push("reset", 32'd0, 32'd0, 32'd0, ALU_XXX, 1'b0);
        pop_check();
        check("reset.hazard", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDU r3(5), r4(7), no forwarding
        set_id(5'd3, 32'd5, 5'd4, 32'd7, 5'd6, ALU_ADDU);
        push("addu", 32'd5, 32'd7, 32'd7, ALU_ADDU, 1'b1);
        step();
        pop_check();

        // Forwarding on the held instruction: MEM beats WB, then WB alone
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'h10;
        wb_fwd_en = 1'b1; wb_fwd_addr = 5'd3; wb_fwd_data = 32'h20;
        #1;
        check("fwd_mem_prio", alu_a, 32'h10);
        mem_fwd_en = 1'b0;
        #1;
        check("fwd_wb", alu_a, 32'h20);
        wb_fwd_addr = 5'd4; wb_fwd_data = 32'h77;
        #1;
        check("fwd_wb_rt.b", alu_b, 32'h77);
        check("fwd_wb_rt.sd", ex_store_data, 32'h77);
        wb_fwd_en = 1'b0;

        // rs = r0 with forwards targeting r0: never forwarded
        set_id(5'd0, 32'd0, 5'd4, 32'd7, 5'd6, ALU_ADDU);
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'hFF;
        wb_fwd_en = 1'b1; wb_fwd_addr = 5'd0; wb_fwd_data = 32'hFF;
        push("fwd_r0", 32'd0, 32'd7, 32'd7, ALU_ADDU, 1'b1);
        step();
        pop_check();
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;

        // Immediate extension and shamt substitution
        set_id(5'd3, 32'd5, 5'd4, 32'd7, 5'd4, ALU_ADDU);
        id_b_imm = 1'b1; id_imm = 16'h8000; id_imm_sext = 1'b1;
        push("imm_sext", 32'd5, 32'hFFFF8000, 32'd7, ALU_ADDU, 1'b1);
        step();
        pop_check();
        id_imm_sext = 1'b0; id_aluop = ALU_OR;
        push("imm_zext", 32'd5, 32'h00008000, 32'd7, ALU_OR, 1'b1);
        step();
        pop_check();
        set_id(5'd7, 32'd99, 5'd2, 32'd3, 5'd8, ALU_SLL);
        id_a_shamt = 1'b1; id_shamt = 5'd4;
        push("sll", 32'd4, 32'd3, 32'd3, ALU_SLL, 1'b1);
        step();
        pop_check();

        // Load-use: LW r5 in EX, dependent ADDU in ID
        set_lw_r5();
        push("lw", 32'h100, 32'd4, 32'd0, ALU_ADDU, 1'b1);
        step();
        pop_check();
        set_id(5'd5, 32'd0, 5'd2, 32'd3, 5'd6, ALU_ADDU);
        #1;
        check("lu.stall", {31'd0, hazard_stall}, 32'd1);
        step();
        check("lu.bubble_v", {31'd0, ex_valid}, 32'd0);
        check("lu.bubble_op", {28'd0, alu_op}, {28'd0, ALU_XXX});
        check("lu.bubble_dest", {27'd0, ex_dest}, 32'd0);
        check("lu.release", {31'd0, hazard_stall}, 32'd0);
        wb_fwd_en = 1'b1; wb_fwd_addr = 5'd5; wb_fwd_data = 32'hABCD;
        push("lu.dep", 32'hABCD, 32'd3, 32'd3, ALU_ADDU, 1'b1);
        step();
        pop_check();

        // ext_stall for 3 cycles: EX holds while ID changes
        set_id(5'd9, 32'd1, 5'd10, 32'd2, 5'd11, ALU_XOR);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("ext_hold", 32'hABCD, 32'd3, 32'd3, ALU_ADDU, 1'b1);
            step();
            pop_check();
        end
        ext_stall = 1'b0;
        wb_fwd_en = 1'b0;
        push("ext_release", 32'd1, 32'd2, 32'd2, ALU_XOR, 1'b1);
        step();
        pop_check();

        // ext_stall with a load-use hazard: stall visible, no bubble
        set_lw_r5();
        step();
        set_id(5'd5, 32'd0, 5'd2, 32'd3, 5'd6, ALU_ADDU);
        ext_stall = 1'b1;
        #1;
        check("xs.stall", {31'd0, hazard_stall}, 32'd1);
        step();
        check("xs.hold_v", {31'd0, ex_valid}, 32'd1);
        check("xs.hold_mr", {31'd0, ex_mem_read}, 32'd1);
        check("xs.stall2", {31'd0, hazard_stall}, 32'd1);
        ext_stall = 1'b0;

        // flush together with hazard: bubble, stall gone next cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("fl.v", {31'd0, ex_valid}, 32'd0);
        check("fl.mr", {31'd0, ex_mem_read}, 32'd0);
        check("fl.stall", {31'd0, hazard_stall}, 32'd0);

        // rt match only counts when rt is a source
        set_lw_r5();
        step();
        set_id(5'd7, 32'd0, 5'd5, 32'd0, 5'd6, ALU_ADDU);
        id_uses_rt = 1'b0;
        #1;
        check("rt_unused", {31'd0, hazard_stall}, 32'd0);
        id_uses_rt = 1'b1;
        #1;
        check("rt_used", {31'd0, hazard_stall}, 32'd1);

        // Reset mid-stall clears everything without a clock edge
        rst_n = 1'b0;
        #1;
        check("rst.v", {31'd0, ex_valid}, 32'd0);
        check("rst.op", {28'd0, alu_op}, {28'd0, ALU_XXX});
        check("rst.a", alu_a, 32'd0);
        check("rst.b", alu_b, 32'd0);
        check("rst.stall", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst.no_bubble_stall", {31'd0, hazard_stall}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
